// File: rtl/ysyx_22040237_pkg.sv
// rtl/ysyx_22040237_pkg.sv - shared LSU defines: FSM states, ls_info bit indices, size masks
package ysyx_22040237_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_WB       = 2'd3
    } lsu_state_e;

    localparam int LS_INFO_W = 7;
    localparam int LS_LOAD   = 0;
    localparam int LS_STORE  = 1;
    localparam int LS_USIGN  = 2;
    localparam int LS_BYTE   = 3;
    localparam int LS_DB     = 4;
    localparam int LS_WORD   = 5;
    localparam int LS_DW     = 6;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } ls_size_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input ls_size_e sz);
        case (sz)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // Widest set flag wins; with no size flag the access degrades to a byte.
    function automatic ls_size_e decode_size(input logic [LS_INFO_W-1:0] info);
        if (info[LS_DW])        return SZ_D;
        else if (info[LS_WORD]) return SZ_W;
        else if (info[LS_DB])   return SZ_H;
        else                    return SZ_B;
    endfunction

    function automatic logic is_misaligned(input ls_size_e sz, input logic [2:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// rtl/ysyx_22040237_lsu_align.sv - store lane mask/data shift and load extract/extend
module ysyx_22040237_lsu_align
    import ysyx_22040237_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  ls_size_e        size,
    input  logic [2:0]      offset,
    input  logic            usign,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [5:0]      bit_shift;
    logic [XLEN-1:0] rshift;

    assign bit_shift = {offset, 3'b000};
    assign wmask     = size_mask(size) << offset;
    assign wdata     = store_data << bit_shift;
    assign rshift    = rdata >> bit_shift;

    always_comb begin
        load_data = rshift;
        case (size)
            SZ_B: load_data = usign ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                    : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            SZ_H: load_data = usign ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                    : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            SZ_W: load_data = usign ? {{(XLEN-32){1'b0}}, rshift[31:0]}
                                    : {{(XLEN-32){rshift[31]}}, rshift[31:0]};
            default: load_data = rshift;
        endcase
    end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// rtl/ysyx_22040237_lsu.sv - load/store unit: one outstanding access, single-entry writeback register
module ysyx_22040237_lsu
    import ysyx_22040237_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic                 rd_wr_en_i,
    input  logic [4:0]           rd_idx_i,
    input  logic [XLEN-1:0]      alu_res_i,
    input  logic [LS_INFO_W-1:0] ls_info_bus_i,
    input  logic [XLEN-1:0]      rs2_store_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [XLEN-1:0]      mem_addr_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    output logic [7:0]           mem_wmask_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [XLEN-1:0]      mem_rdata_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic                 wb_rd_wr_en_o,
    output logic [4:0]           wb_rd_idx_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic                 misalign_o
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, sdata_q;
    ls_size_e        size_q, in_size;
    logic            usign_q, store_q, rd_wr_en_q;
    logic [4:0]      rd_idx_q;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_idx_q, wb_idx_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            misalign_q, misalign_d;
    logic            wb_load, latch_req, is_ls;
    logic [7:0]      al_wmask;
    logic [XLEN-1:0] al_wdata, al_load;

    assign in_size = decode_size(ls_info_bus_i);
    assign is_ls   = ls_info_bus_i[LS_LOAD] | ls_info_bus_i[LS_STORE];

    ysyx_22040237_lsu_align #(.XLEN(XLEN)) u_align (
        .size       (size_q),
        .offset     (addr_q[2:0]),
        .usign      (usign_q),
        .store_data (sdata_q),
        .rdata      (mem_rdata_i),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_comb begin
        state_d    = state_q;
        wb_load    = 1'b0;
        wb_we_d    = 1'b0;
        wb_idx_d   = rd_idx_q;
        wb_data_d  = '0;
        latch_req  = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i) begin
                    if (!is_ls) begin
                        state_d   = ST_WB;
                        wb_load   = 1'b1;
                        wb_we_d   = rd_wr_en_i;
                        wb_idx_d  = rd_idx_i;
                        wb_data_d = alu_res_i;
                    end else if (is_misaligned(in_size, alu_res_i[2:0])) begin
                        state_d    = ST_WB;
                        wb_load    = 1'b1;
                        wb_idx_d   = rd_idx_i;
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = ST_REQ;
                        latch_req = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    if (store_q) begin
                        state_d = ST_WB;
                        wb_load = 1'b1;
                    end else if (mem_rvalid_i) begin
                        // Response may arrive together with the grant.
                        state_d   = ST_WB;
                        wb_load   = 1'b1;
                        wb_we_d   = rd_wr_en_q;
                        wb_data_d = al_load;
                    end else begin
                        state_d = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    state_d   = ST_WB;
                    wb_load   = 1'b1;
                    wb_we_d   = rd_wr_en_q;
                    wb_data_d = al_load;
                end
            end
            ST_WB: begin
                if (wb_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            sdata_q    <= '0;
            size_q     <= SZ_B;
            usign_q    <= 1'b0;
            store_q    <= 1'b0;
            rd_wr_en_q <= 1'b0;
            rd_idx_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
            if (latch_req) begin
                addr_q     <= alu_res_i;
                sdata_q    <= rs2_store_i;
                size_q     <= in_size;
                usign_q    <= ls_info_bus_i[LS_USIGN];
                store_q    <= ls_info_bus_i[LS_STORE];
                rd_wr_en_q <= rd_wr_en_i;
                rd_idx_q   <= rd_idx_i;
            end
            if (wb_load) begin
                wb_we_q   <= wb_we_d;
                wb_idx_q  <= wb_idx_d;
                wb_data_q <= wb_data_d;
            end
        end
    end

    assign ex_ready_o    = rst && (state_q == ST_IDLE);
    assign mem_req_o     = (state_q == ST_REQ);
    assign mem_we_o      = mem_req_o & store_q;
    assign mem_addr_o    = mem_req_o ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_wdata_o   = mem_we_o ? al_wdata : '0;
    assign mem_wmask_o   = mem_we_o ? al_wmask : 8'h00;
    assign wb_valid_o    = (state_q == ST_WB);
    assign wb_rd_wr_en_o = wb_we_q;
    assign wb_rd_idx_o   = wb_idx_q;
    assign wb_data_o     = wb_data_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb/tb_ysyx_22040237_lsu.sv - self-checking bench: directed vector table, corner sequences, random vs model
module tb_ysyx_22040237_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic        rd_wr_en_i = 1'b0;
    logic [4:0]  rd_idx_i = '0;
    logic [63:0] alu_res_i = '0;
    logic [6:0]  ls_info_bus_i = '0;
    logic [63:0] rs2_store_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic        wb_rd_wr_en_o;
    logic [4:0]  wb_rd_idx_o;
    logic [63:0] wb_data_o;
    logic        misalign_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    ysyx_22040237_lsu dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
        .alu_res_i(alu_res_i), .ls_info_bus_i(ls_info_bus_i), .rs2_store_i(rs2_store_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_wr_en_o(wb_rd_wr_en_o),
        .wb_rd_idx_o(wb_rd_idx_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [6:0]  info;
        logic [63:0] addr;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic        we;
        logic [4:0]  idx;
        int          gnt_dly;
        int          rsp_dly;
        int          rdy_dly;
        logic [63:0] e_data;
        logic [63:0] e_wdata;
        logic [7:0]  e_mask;
        logic        e_we;
        logic        e_mis;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] info, input logic [63:0] addr,
                                input logic [63:0] rs2, input logic [63:0] rdata, input logic we,
                                input logic [4:0] idx, input int g, input int r, input int w,
                                input logic [63:0] e_data, input logic [63:0] e_wdata,
                                input logic [7:0] e_mask, input logic e_we, input logic e_mis);
        vec_t v;
        v.nm = nm; v.info = info; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.we = we; v.idx = idx; v.gnt_dly = g; v.rsp_dly = r; v.rdy_dly = w;
        v.e_data = e_data; v.e_wdata = e_wdata; v.e_mask = e_mask; v.e_we = e_we; v.e_mis = e_mis;
        return v;
    endfunction

    // Reference: access width in bytes, lane offset, natural-alignment rule, byte-lane arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        o = v;
        int          n, off;
        logic [63:0] m, val;
        logic        ld, st;
        ld  = v.info[0];
        st  = v.info[1];
        n   = v.info[6] ? 8 : v.info[5] ? 4 : v.info[4] ? 2 : 1;
        off = int'(v.addr % 8);
        o.e_mis   = (ld || st) && (off % n != 0);
        o.e_wdata = '0;
        o.e_mask  = '0;
        o.e_data  = '0;
        o.e_we    = 1'b0;
        if (!ld && !st) begin
            o.e_data = v.addr;
            o.e_we   = v.we;
        end else if (!o.e_mis && st) begin
            o.e_wdata = v.rs2 << (8 * off);
            o.e_mask  = 8'(((1 << n) - 1) << off);
        end else if (!o.e_mis) begin
            m   = (n == 8) ? ~64'd0 : ((64'd1 << (8 * n)) - 64'd1);
            val = (v.rdata >> (8 * off)) & m;
            if (!v.info[2] && val[8*n-1]) val = val | ~m;
            o.e_data = val;
            o.e_we   = v.we;
        end
        return o;
    endfunction

    task automatic run_txn(input vec_t v);
        logic ld, st, chk_data;
        ld = v.info[0];
        st = v.info[1];
        chk_data = !v.e_mis && !st;
        ex_valid_i = 1'b1; ls_info_bus_i = v.info; alu_res_i = v.addr;
        rs2_store_i = v.rs2; rd_wr_en_i = v.we; rd_idx_i = v.idx;
        chk({v.nm, ".ex_ready"}, 64'(ex_ready_o), 64'd1);
        step();
        ex_valid_i = 1'b0; ls_info_bus_i = 7'($urandom); alu_res_i = {$urandom, $urandom};
        if ((ld || st) && !v.e_mis) begin
            for (int i = 0; i <= v.gnt_dly; i++) begin
                mem_rdata_i = {$urandom, $urandom};
                if (i == v.gnt_dly) begin
                    mem_gnt_i = 1'b1;
                    if (ld && v.rsp_dly == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = v.rdata;
                    end
                end
                chk({v.nm, ".req"}, 64'(mem_req_o), 64'd1);
                chk({v.nm, ".addr"}, mem_addr_o, {v.addr[63:3], 3'b000});
                chk({v.nm, ".we"}, 64'(mem_we_o), 64'(st));
                chk({v.nm, ".wmask"}, 64'(mem_wmask_o), 64'(v.e_mask));
                chk({v.nm, ".wdata"}, mem_wdata_o, v.e_wdata);
                chk({v.nm, ".ex_busy"}, 64'(ex_ready_o), 64'd0);
                step();
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            end
            if (ld && v.rsp_dly > 0) begin
                for (int j = 0; j < v.rsp_dly; j++) begin
                    mem_rdata_i = {$urandom, $urandom};
                    if (j == v.rsp_dly - 1) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = v.rdata;
                    end
                    chk({v.nm, ".wait_noreq"}, 64'(mem_req_o), 64'd0);
                    chk({v.nm, ".wait_nowb"}, 64'(wb_valid_o), 64'd0);
                    step();
                    mem_rvalid_i = 1'b0;
                end
            end
        end
        chk({v.nm, ".wb_noreq"}, 64'(mem_req_o), 64'd0);
        for (int k = 0; k <= v.rdy_dly; k++) begin
            wb_ready_i = (k == v.rdy_dly);
            mem_rdata_i = {$urandom, $urandom};
            chk({v.nm, ".misalign"}, 64'(misalign_o), (k == 0) ? 64'(v.e_mis) : 64'd0);
            chk({v.nm, ".wb_valid"}, 64'(wb_valid_o), 64'd1);
            chk({v.nm, ".wb_we"}, 64'(wb_rd_wr_en_o), 64'(v.e_we));
            if (chk_data) begin
                chk({v.nm, ".wb_data"}, wb_data_o, v.e_data);
                chk({v.nm, ".wb_idx"}, 64'(wb_rd_idx_o), 64'(v.idx));
            end
            step();
        end
        wb_ready_i = 1'b0;
        chk({v.nm, ".wb_done"}, 64'(wb_valid_o), 64'd0);
        chk({v.nm, ".idle"}, 64'(ex_ready_o), 64'd1);
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk("sb",   7'h0A, 64'h8000_0003, 64'hAB, 64'h0, 1'b1, 5'd3, 0, 0, 0,
                     64'h0, 64'h0000_0000_AB00_0000, 8'h08, 1'b0, 1'b0);
        tbl[1]  = mk("lh",   7'h11, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 1'b1, 5'd7, 1, 1, 0,
                     64'hFFFF_FFFF_FFFF_8001, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[2]  = mk("lhu",  7'h15, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 1'b1, 5'd8, 0, 2, 1,
                     64'h0000_0000_0000_8001, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[3]  = mk("lw_mis", 7'h21, 64'h8000_0002, 64'h0, 64'h0, 1'b1, 5'd9, 0, 0, 2,
                     64'h0, 64'h0, 8'h00, 1'b0, 1'b1);
        tbl[4]  = mk("alu",  7'h00, 64'h1234, 64'h0, 64'h0, 1'b1, 5'd5, 0, 0, 3,
                     64'h1234, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[5]  = mk("ld",   7'h41, 64'h8000_1000, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd10, 4, 2, 0,
                     64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[6]  = mk("sd",   7'h42, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 5'd0, 2, 0, 1,
                     64'h0, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1'b0);
        tbl[7]  = mk("sw4",  7'h22, 64'h8000_0004, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b1, 5'd1, 0, 0, 0,
                     64'h0, 64'hCAFE_F00D_0000_0000, 8'hF0, 1'b0, 1'b0);
        tbl[8]  = mk("lb7",  7'h09, 64'h8000_0007, 64'h0, 64'hFE00_0000_0000_0000, 1'b1, 5'd11, 0, 1, 0,
                     64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[9]  = mk("lbu7", 7'h0D, 64'h8000_0007, 64'h0, 64'hFE00_0000_0000_0000, 1'b1, 5'd12, 1, 0, 0,
                     64'h0000_0000_0000_00FE, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[10] = mk("sh_mis", 7'h12, 64'h8000_0001, 64'h55, 64'h0, 1'b1, 5'd13, 0, 0, 0,
                     64'h0, 64'h0, 8'h00, 1'b0, 1'b1);
        tbl[11] = mk("lw_g0", 7'h21, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 1'b1, 5'd14, 2, 0, 0,
                     64'hFFFF_FFFF_89AB_CDEF, 64'h0, 8'h00, 1'b1, 1'b0);
        tbl[12] = mk("lwu",  7'h25, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 1'b0, 5'd15, 0, 3, 0,
                     64'h0000_0000_89AB_CDEF, 64'h0, 8'h00, 1'b0, 1'b0);
        tbl[13] = mk("ld_mis", 7'h41, 64'h8000_0004, 64'h0, 64'h0, 1'b1, 5'd16, 0, 0, 0,
                     64'h0, 64'h0, 8'h00, 1'b0, 1'b1);

        #1;
        chk("rst.ex_ready", 64'(ex_ready_o), 64'd0);
        chk("rst.req", 64'(mem_req_o), 64'd0);
        chk("rst.wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst.wb_data", wb_data_o, 64'd0);
        chk("rst.misalign", 64'(misalign_o), 64'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst.release_ready", 64'(ex_ready_o), 64'd1);
        step();

        for (int t = 0; t < 14; t++) run_txn(tbl[t]);

        // Reset while waiting for a load response; late response must be dropped.
        ex_valid_i = 1'b1; ls_info_bus_i = 7'h41; alu_res_i = 64'h8000_2000; rd_wr_en_i = 1'b1; rd_idx_i = 5'd4;
        step();
        ex_valid_i = 1'b0; ls_info_bus_i = 7'h00;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("rstmid.in_wait", 64'(mem_req_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("rstmid.ex_ready_low", 64'(ex_ready_o), 64'd0);
        chk("rstmid.wb_valid", 64'(wb_valid_o), 64'd0);
        step();
        rst = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        mem_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rstmid.no_wb", 64'(wb_valid_o), 64'd0);
            chk("rstmid.idle", 64'(ex_ready_o), 64'd1);
            chk("rstmid.wb_we", 64'(wb_rd_wr_en_o), 64'd0);
            step();
        end

        for (int r = 0; r < 60; r++) begin
            vec_t v;
            int   kind, szb;
            kind = int'($urandom_range(0, 2));
            szb  = int'($urandom_range(3, 6));
            v.nm = "rnd";
            v.addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) v.addr[2:0] = v.addr[2:0] & ~3'((1 << (szb - 3)) - 1);
            v.rs2 = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.we = 1'($urandom);
            v.idx = 5'($urandom);
            v.gnt_dly = int'($urandom_range(0, 3));
            v.rsp_dly = int'($urandom_range(0, 3));
            v.rdy_dly = int'($urandom_range(0, 2));
            v.info = '0;
            if (kind == 1) v.info = 7'((1 << szb) | 1 | (int'($urandom_range(0, 1)) << 2));
            if (kind == 2) v.info = 7'((1 << szb) | 2);
            run_txn(model(v));
            if ($urandom_range(0, 3) == 0) begin
                mem_rvalid_i = 1'b1;
                step();
                mem_rvalid_i = 1'b0;
                chk("rnd.stray_rvalid", 64'(wb_valid_o), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_22040237_lsu.md
YSYX_22040237_LSU -- requirements
Module: ysyx_22040237_lsu

Interface
REQ-001 Parameter: XLEN, 64, datapath and address width (RV64, fixed).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid_i  in  1  execute stage holds a valid instruction.
REQ-005 ex_ready_o  out  1  LSU accepts the instruction this cycle.
REQ-006 rd_wr_en_i  in  1, rd_idx_i  in  5  destination write-enable and index.
REQ-007 alu_res_i  in  64  ALU result; the effective address for load/store.
REQ-008 ls_info_bus_i  in  7  {dw, word, db, byte, usign, store, load}, bit 0 = load.
REQ-009 rs2_store_i  in  64  store data, least-significant bytes used.
REQ-010 mem_req_o  out  1, mem_we_o  out  1, mem_addr_o  out  64 (bits[2:0]=0), mem_wdata_o  out  64, mem_wmask_o  out  8.
REQ-011 mem_gnt_i  in  1, mem_rvalid_i  in  1, mem_rdata_i  in  64  memory grant, read-response valid, read data.
REQ-012 wb_valid_o  out  1, wb_ready_i  in  1, wb_rd_wr_en_o  out  1, wb_rd_idx_o  out  5, wb_data_o  out  64.
REQ-013 misalign_o  out  1  one-cycle pulse on a misaligned access.

Function
REQ-014 FSM states IDLE, REQ, WAIT_RSP, WB; ex_ready_o = 1 only in IDLE.
REQ-015 IDLE, accept with neither load nor store set -> capture rd/alu_res into the WB register, go to WB (1-cycle latency).
REQ-016 IDLE, accept with load or store set -> latch address, size, sign, data; go to REQ.
REQ-017 Size decode: byte=1 B, db=2 B, word=4 B, dw=8 B; exactly one is set for an LS op.
REQ-018 Misaligned: db with addr[0]=1, word with addr[1:0]!=0, dw with addr[2:0]!=0 -> no memory request, misalign_o pulses 1 cycle, go to WB with wb_rd_wr_en_o=0.
REQ-019 REQ: mem_req_o=1, mem_addr_o={addr[63:3],3'b0}; held stable until mem_gnt_i=1.
REQ-020 Store mask = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]; wdata = rs2 shifted left by 8*addr[2:0].
REQ-021 Store granted -> WB with wb_rd_wr_en_o=0; load granted -> WAIT_RSP.
REQ-022 WAIT_RSP: on mem_rvalid_i, shift rdata right by 8*addr[2:0], truncate to size, zero-extend if usign else sign-extend; go to WB.
REQ-023 mem_rvalid_i in the grant cycle is accepted (REQ goes directly to WB).
REQ-024 WB: wb_valid_o=1 with outputs held stable until wb_ready_i=1, then IDLE.
REQ-025 WB register updates only on a state transition into WB.
REQ-026 mem_rvalid_i outside WAIT_RSP/grant cycle is ignored.

Reset
REQ-027 On rst=0: state IDLE, all outputs 0 except ex_ready_o, which is 1 once rst deasserts.
REQ-028 Reset mid-transaction abandons it; no partial writeback; later stray mem_rvalid_i is ignored.

Structure
REQ-029 State enum, ls_info bit indices and size masks go in the shared ysyx_22040237 defines package.
REQ-030 One sub-module, ysyx_22040237_lsu_align: combinational mask/wdata shift and load extract/extend.

Verification
REQ-031 sb: addr 0x8000_0003, rs2 0xAB -> mem_addr 0x8000_0000, wmask 0x08, wdata[31:24]=0xAB, wb_rd_wr_en_o=0.
REQ-032 lh: addr 0x...06, rdata 0x8001_0000_0000_0000 -> wb_data 0xFFFF_FFFF_FFFF_8001; lhu -> 0x8001.
REQ-033 lw at addr 0x...02 -> misalign_o pulse, no mem_req_o, wb_valid_o with wb_rd_wr_en_o=0.
REQ-034 ALU op rd=5, alu_res 0x1234 -> wb_valid_o next cycle, data 0x1234; wb_ready_i low 3 cycles -> held.
REQ-035 ld, gnt delayed 4 cycles, rvalid 2 cycles later -> mem_addr/req stable throughout, single WB.
REQ-036 rst low during WAIT_RSP, rvalid after release -> no wb_valid_o, state IDLE.
